wb_cmd_bridge: RTL and testbench

- Parametrised successor to the fixed 34-bit host/master command path between the multi-cycle core's controller/datapath and memory.
- Accepts host commands (cmd_stb/cmd_word) into a CMD_DEPTH FIFO and executes them one at a time as Wishbone classic cycles.
- Returns one response per command on rsp_stb/rsp_word.
- New over the previous generation: configurable address/data width, byte selects, command buffering, error reporting, overflow flag.

---
 rtl/wb_cmd_bridge_if.sv | 33 +++
 rtl/wb_cmd_bridge.sv | 151 +++++++++++++++
 tb/tb_wb_cmd_bridge.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_bridge_if
// Brief    : Wishbone classic master/slave signal bundle for wb_cmd_bridge.
// Revision : 1.0
// ============================================================================
interface wb_cmd_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int c_SEL_W = DATA_W / 8;

    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [ADDR_W-1:0]   wb_adr_o;
    logic [c_SEL_W-1:0]  wb_sel_o;
    logic [DATA_W-1:0]   wb_dat_o;
    logic [DATA_W-1:0]   wb_dat_i;
    logic                wb_ack_i;
    logic                wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_bridge
// Brief    : Buffers host commands in a FIFO and runs them one at a time as
//            Wishbone classic cycles, returning one response per command.
//            Optional bus watchdog: define WB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module wb_cmd_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire                               clk,
    input  wire                               reset,
    input  wire                               cmd_stb,
    input  wire [DATA_W+ADDR_W+DATA_W/8:0]    cmd_word,
    output logic                              cmd_busy,
    output logic                              cmd_ovf,
    output logic                              rsp_stb,
    output logic [DATA_W+1:0]                 rsp_word,
    wb_cmd_bridge_if.master                   wb
);
    localparam int c_SEL_W = DATA_W / 8;
    localparam int c_CMD_W = 1 + c_SEL_W + ADDR_W + DATA_W;
    localparam int c_PTR_W = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CMD_W-1:0]   r_mem [CMD_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_term;
    logic                 w_err;
    logic                 w_timeout;
    logic [c_CMD_W-1:0]   w_head;
    logic [c_PTR_W:0]     w_count_nxt;

    assign w_push      = cmd_stb && !cmd_busy;
    assign w_term      = (r_state == S_BUS) && (wb.wb_ack_i || wb.wb_err_i || w_timeout);
    assign w_pop       = w_term;
    assign w_err       = wb.wb_err_i || w_timeout;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_count_nxt = r_count + {{c_PTR_W{1'b0}}, w_push} - {{c_PTR_W{1'b0}}, w_pop};

`ifdef WB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    // Held at zero outside BUS so every cycle starts counting from its first BUS cycle.
    assign w_timeout = (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
        end else if (r_state != S_BUS) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Storage needs no reset: only entries covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            cmd_busy <= 1'b0;
            cmd_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count  <= w_count_nxt;
            cmd_busy <= (w_count_nxt == (c_PTR_W + 1)'(CMD_DEPTH));
            if (cmd_stb && cmd_busy) begin
                cmd_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_sel_o <= '0;
            wb.wb_dat_o <= '0;
            rsp_stb     <= 1'b0;
            rsp_word    <= '0;
        end else begin
            rsp_stb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        wb.wb_we_o  <= w_head[c_CMD_W-1];
                        wb.wb_sel_o <= w_head[c_CMD_W-2 -: c_SEL_W];
                        wb.wb_adr_o <= w_head[DATA_W +: ADDR_W];
                        wb.wb_dat_o <= w_head[DATA_W-1:0];
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (w_term) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        rsp_stb     <= 1'b1;
                        rsp_word    <= {w_err, wb.wb_we_o,
                                        (!wb.wb_we_o && !w_err) ? wb.wb_dat_i : {DATA_W{1'b0}}};
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_bridge
// Brief    : Directed bench for wb_cmd_bridge with a response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_wb_cmd_bridge;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int SEL_W       = DATA_W / 8;
    localparam int CMD_DEPTH   = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int CMD_W       = 1 + SEL_W + ADDR_W + DATA_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_stb = 1'b0;
    logic [CMD_W-1:0]   cmd_word = '0;
    logic               cmd_busy;
    logic               cmd_ovf;
    logic               rsp_stb;
    logic [DATA_W+1:0]  rsp_word;

    wb_cmd_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    wb_cmd_bridge #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CMD_DEPTH   (CMD_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_stb  (cmd_stb),
        .cmd_word (cmd_word),
        .cmd_busy (cmd_busy),
        .cmd_ovf  (cmd_ovf),
        .rsp_stb  (rsp_stb),
        .rsp_word (rsp_word),
        .wb       (wb)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    logic [DATA_W+1:0] exp_q [$];

    logic              slv_stall = 1'b0;
    int                slv_delay = 0;
    logic [ADDR_W-1:0] slv_err_addr = '1;
    logic [DATA_W-1:0] slv_rbase = '0;
    int                bus_cnt = 0;

    int   rsp_seen = 0;
    int   cyc_run = 0;
    int   last_cyc_len = 0;
    logic prev_rsp = 1'b0;
    int   base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Slave: responds bus_cnt >= slv_delay negedges into the cycle; err on a chosen address.
    initial begin
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (wb.wb_cyc_o && wb.wb_stb_o) begin
                if (!slv_stall && bus_cnt >= slv_delay) begin
                    wb.wb_ack_i = 1'b1;
                    wb.wb_err_i = (wb.wb_adr_o == slv_err_addr);
                    wb.wb_dat_i = slv_rbase ^ wb.wb_adr_o;
                end else begin
                    wb.wb_dat_i = 32'hBAD0_BAD0;
                end
                bus_cnt++;
            end else begin
                bus_cnt     = 0;
                wb.wb_ack_i = 1'b0;
                wb.wb_err_i = 1'b0;
                wb.wb_dat_i = '0;
            end
        end
    end

    // Response monitor and scoreboard pop.
    initial begin
        forever begin
            @(negedge clk);
            if (wb.wb_cyc_o) begin
                cyc_run++;
            end else if (cyc_run != 0) begin
                last_cyc_len = cyc_run;
                cyc_run      = 0;
            end
            if (rsp_stb) begin
                rsp_seen++;
                chk("rsp_single_pulse", {63'd0, prev_rsp}, 64'd0);
                chk("rsp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    chk("rsp_word", {30'd0, rsp_word}, {30'd0, exp_q.pop_front()});
                end
            end
            prev_rsp = rsp_stb;
        end
    end

    task automatic send(input logic we, input logic [SEL_W-1:0] sel,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        cmd_stb  = 1'b1;
        cmd_word = {we, sel, addr, wdata};
        @(posedge clk); #1;
        cmd_stb  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || wb.wb_cyc_o) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_budget", {63'd0, n < budget}, 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
        chk("rst_stb", {63'd0, wb.wb_stb_o}, 64'd0);
        chk("rst_adr", {32'd0, wb.wb_adr_o}, 64'd0);
        chk("rst_busy", {63'd0, cmd_busy}, 64'd0);
        chk("rst_ovf", {63'd0, cmd_ovf}, 64'd0);
        chk("rst_rsp_stb", {63'd0, rsp_stb}, 64'd0);
        chk("rst_rsp_word", {30'd0, rsp_word}, 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Single read, ack 3 cycles after cyc
        slv_delay = 3;
        slv_rbase = 32'hDEADBEEF ^ 32'h100;
        exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
        send(1'b0, 4'hF, 32'h100, 32'h0);
        chk("rd_cyc_cycle1", {63'd0, wb.wb_cyc_o}, 64'd0);
        @(posedge clk); #1;
        chk("rd_cyc_cycle2", {63'd0, wb.wb_cyc_o}, 64'd1);
        chk("rd_stb", {63'd0, wb.wb_stb_o}, 64'd1);
        chk("rd_adr", {32'd0, wb.wb_adr_o}, 64'h100);
        chk("rd_we", {63'd0, wb.wb_we_o}, 64'd0);
        chk("rd_sel", {60'd0, wb.wb_sel_o}, 64'hF);
        wait_done(50);
        chk("rd_cyc_len", 64'(last_cyc_len), 64'd4);

        // Byte write, immediate ack
        slv_delay = 0;
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        send(1'b1, 4'b0010, 32'h20, 32'h0000AB00);
        @(posedge clk); #1;
        chk("wr_cyc", {63'd0, wb.wb_cyc_o}, 64'd1);
        chk("wr_we", {63'd0, wb.wb_we_o}, 64'd1);
        chk("wr_sel", {60'd0, wb.wb_sel_o}, 64'h2);
        chk("wr_dat", {32'd0, wb.wb_dat_o}, 64'h0000AB00);
        chk("wr_adr", {32'd0, wb.wb_adr_o}, 64'h20);
        wait_done(50);
        chk("wr_cyc_len", 64'(last_cyc_len), 64'd1);

        // FIFO fill and overflow with slave stalled
        slv_stall = 1'b1;
        slv_rbase = 32'hA5A50000;
        for (int i = 0; i < 6; i++) begin
            cmd_stb  = 1'b1;
            cmd_word = {1'b0, 4'hF, 32'(i * 4), 32'h0};
            if (i < 4) begin
                exp_q.push_back({2'b00, 32'hA5A50000 ^ 32'(i * 4)});
            end
            @(posedge clk); #1;
            if (i == 2) chk("fill_busy_after3", {63'd0, cmd_busy}, 64'd0);
            if (i == 3) chk("fill_busy_after4", {63'd0, cmd_busy}, 64'd1);
        end
        cmd_stb = 1'b0;
        chk("fill_ovf", {63'd0, cmd_ovf}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("fill_busy_hold", {63'd0, cmd_busy}, 64'd1);
        base = rsp_seen;
        slv_stall = 1'b0;
        wait_done(100);
        chk("fill_rsp_count", 64'(rsp_seen - base), 64'd4);
        chk("fill_busy_clear", {63'd0, cmd_busy}, 64'd0);
        chk("fill_ovf_sticky", {63'd0, cmd_ovf}, 64'd1);

        // Bus error with ack and err together; next command still runs
        slv_err_addr = 32'h40;
        slv_delay    = 1;
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        send(1'b0, 4'hF, 32'h40, 32'h0);
        exp_q.push_back({1'b0, 1'b0, 32'hA5A50000 ^ 32'h44});
        send(1'b0, 4'hF, 32'h44, 32'h0);
        wait_done(50);
        slv_err_addr = '1;
        slv_delay    = 0;

        // Unresponsive slave
        base = rsp_seen;
        slv_stall = 1'b1;
`ifdef WB_TIMEOUT_EN
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        send(1'b0, 4'hF, 32'h80, 32'h0);
        wait_done(60);
        chk("to_cyc_len", 64'(last_cyc_len), 64'(TIMEOUT_CYC));
        chk("to_rsp_count", 64'(rsp_seen - base), 64'd1);
        slv_stall = 1'b0;
`else
        exp_q.push_back({1'b0, 1'b0, 32'hA5A50000 ^ 32'h80});
        send(1'b0, 4'hF, 32'h80, 32'h0);
        repeat (101) @(posedge clk);
        #1;
        chk("hang_cyc_high", {63'd0, wb.wb_cyc_o}, 64'd1);
        chk("hang_cyc_run", {63'd0, cyc_run >= 100}, 64'd1);
        chk("hang_no_rsp", 64'(rsp_seen - base), 64'd0);
        slv_stall = 1'b0;
        wait_done(20);
`endif

        // Reset while a cycle is open and two commands are queued
        slv_stall = 1'b1;
        base = rsp_seen;
        for (int i = 0; i < 3; i++) begin
            cmd_stb  = 1'b1;
            cmd_word = {1'b0, 4'hF, 32'h200 + 32'(i * 4), 32'h0};
            @(posedge clk); #1;
        end
        cmd_stb = 1'b0;
        chk("rstbus_cyc_before", {63'd0, wb.wb_cyc_o}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rstbus_cyc_async", {63'd0, wb.wb_cyc_o}, 64'd0);
        chk("rstbus_stb_async", {63'd0, wb.wb_stb_o}, 64'd0);
        chk("rstbus_ovf_clear", {63'd0, cmd_ovf}, 64'd0);
        slv_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rstbus_cyc_idle", {63'd0, wb.wb_cyc_o}, 64'd0);
        chk("rstbus_busy", {63'd0, cmd_busy}, 64'd0);
        chk("rstbus_no_rsp", 64'(rsp_seen - base), 64'd0);

        // Bridge still usable after reset
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        send(1'b1, 4'hC, 32'h300, 32'h12340000);
        @(posedge clk); #1;
        chk("post_adr", {32'd0, wb.wb_adr_o}, 64'h300);
        wait_done(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
